ste_rms_ctrl: RTL
=================

Name: ste_rms_ctrl

Overview:
Measurement sequencer for the RMS datapath core.
- Gates the ADC sample stream into the core in windows of programmable length and clears the core at each window start.
- Waits for the core's result update, then captures and flags the result.
- Supports single-shot and continuous modes, abort, and a result timeout.
- Sits between the ADC front-end and the display/range logic.

Parameters:
DATA_W, 16, sample and result width
WIN_CNT_W, 12, width of window-length counter (max window 2^WIN_CNT_W-1 samples)
TIMEOUT_W, 16, width of result-wait timeout counter (clock cycles)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start_i  in  1  start measurement (level sampled in IDLE)
stop_i  in  1  abort; return to IDLE
cont_i  in  1  continuous mode; sampled at each window end
win_len_i  in  WIN_CNT_W  samples per window; latched at start
adc_data_i  in  DATA_W  ADC sample
adc_valid_i  in  1  ADC sample strobe
rms_din_o  out  DATA_W  sample to RMS core
rms_din_update_o  out  1  sample strobe to RMS core
rms_clr_o  out  1  clear pulse to RMS core
rms_dout_i  in  DATA_W  RMS core result
rms_dout_update_i  in  1  RMS core result strobe
result_o  out  DATA_W  captured RMS result
result_valid_o  out  1  one-cycle pulse on capture
busy_o  out  1  high in any state except IDLE
timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs are 0. State is IDLE. Counters and latched win_len are 0.
- FSM states: IDLE, CLEAR, ACQ, WAIT_RES.
- IDLE:
  - start_i=1 and win_len_i!=0 → latch win_len_i, clear timeout_o, go to CLEAR.
  - start_i with win_len_i==0 is ignored; state stays IDLE.
- CLEAR: rms_clr_o=1 for exactly one cycle. Sample counter reset to 0. Next state is ACQ.
- ACQ:
  - Each adc_valid_i is registered and forwarded: rms_din_o/rms_din_update_o follow one cycle later (1-cycle latency). The counter increments.
  - When the counter reaches the latched win_len, the accepting strobe is still forwarded, further strobes are dropped, and the FSM goes to WAIT_RES.
  - adc_valid_i outside ACQ is never forwarded.
- WAIT_RES:
  - Timeout counter increments each cycle.
  - On rms_dout_update_i: result_o<=rms_dout_i, result_valid_o pulses one cycle later. Next state is CLEAR if cont_i=1, else IDLE.
  - If the timeout counter reaches all-ones with no update: timeout_o<=1 (sticky until next accepted start), go to IDLE, result_o unchanged.
- stop_i has priority over every transition. It forces IDLE the next cycle; no clr, strobe or result pulse is issued afterwards. A pending forwarded strobe already registered still completes.
- rms_dout_update_i outside WAIT_RES is ignored.
- start_i while busy is ignored. cont_i changes take effect only at window end.
- result_o holds its value until the next capture.
- Async rst mid-window: immediate return to reset values; no clr pulse is emitted.

Optional Feature:
Macro STE_RMS_CTRL_PEAK_EN.
- Defined:
  - Adds output peak_o [DATA_W-1:0].
  - Tracks the maximum unsigned adc_data_i among forwarded samples in the current window, resetting to 0 in CLEAR.
  - peak_o is updated together with result_o and pulses with the same result_valid_o.
- Undefined: no port, no logic.

Decomposition:
- Package ste_rms_ctrl_pkg: state_t enum {IDLE, CLEAR, ACQ, WAIT_RES}; localparam for timeout terminal value derived from TIMEOUT_W.
- Sub-module ste_rms_ctrl_peak: the peak tracker, instantiated only under STE_RMS_CTRL_PEAK_EN.
- Window and timeout counters stay inline.

Test Plan:
- win_len=4, cont=0, 6 adc strobes after start:
  - 1 clr pulse; exactly 4 rms_din_update_o, each 1 cycle after its strobe.
  - Core returns 0x1234 → result_o=0x1234, one result_valid_o pulse, busy_o low.
- cont=1, win_len=2, three result updates:
  - clr pulses precede each window; 3 result_valid_o pulses; busy_o stays high.
  - Clear cont_i → IDLE after the next result.
- No rms_dout_update_i in WAIT_RES, TIMEOUT_W=4:
  - timeout_o=1 after 15 cycles; return to IDLE; result_o unchanged.
  - Next start clears timeout_o.
- stop_i asserted mid-ACQ after 2 of 8 samples:
  - IDLE next cycle; no further din strobes or result pulse.
  - Restart produces a fresh clr.
- start with win_len_i=0 → stays IDLE, no clr. Async rst asserted in WAIT_RES → all outputs 0 immediately.
- PEAK_EN, samples 5, 0xFF00, 7 → peak_o=0xFF00 with result_valid_o.

Source files
------------

// File: rtl/ste_rms_ctrl_pkg.sv
// rtl/ste_rms_ctrl_pkg.sv - shared types and constants for the RMS measurement sequencer
package ste_rms_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    ACQ      = 2'd2,
    WAIT_RES = 2'd3
  } state_t;

  localparam int DEF_TIMEOUT_W = 16;

  // All-ones terminal value of a timeout counter of width w
  function automatic longint unsigned timeout_term(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  localparam longint unsigned DEF_TIMEOUT_TERM = timeout_term(DEF_TIMEOUT_W);

endpackage

// File: rtl/ste_rms_ctrl_peak.sv
// rtl/ste_rms_ctrl_peak.sv - per-window peak tracker for forwarded ADC samples
module ste_rms_ctrl_peak #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              capture,
  output logic [DATA_W-1:0] peak_o
);

  logic [DATA_W-1:0] run_max;

  // Running maximum of the window; published to peak_o when the result is captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max <= '0;
      peak_o  <= '0;
    end else begin
      if (clr) begin
        run_max <= '0;
      end else if (sample_valid && (sample > run_max)) begin
        run_max <= sample;
      end
      if (capture) begin
        peak_o <= run_max;
      end
    end
  end

endmodule

// File: rtl/ste_rms_ctrl.sv
// rtl/ste_rms_ctrl.sv - RMS measurement sequencer; optional peak output under STE_RMS_CTRL_PEAK_EN
module ste_rms_ctrl
  import ste_rms_ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int WIN_CNT_W = 12,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 cont_i,
  input  logic [WIN_CNT_W-1:0] win_len_i,
  input  logic [DATA_W-1:0]    adc_data_i,
  input  logic                 adc_valid_i,
  output logic [DATA_W-1:0]    rms_din_o,
  output logic                 rms_din_update_o,
  output logic                 rms_clr_o,
  input  logic [DATA_W-1:0]    rms_dout_i,
  input  logic                 rms_dout_update_i,
  output logic [DATA_W-1:0]    result_o,
  output logic                 result_valid_o,
  output logic                 busy_o,
  output logic                 timeout_o
`ifdef STE_RMS_CTRL_PEAK_EN
  ,
  output logic [DATA_W-1:0]    peak_o
`endif
);

  localparam logic [TIMEOUT_W-1:0] TO_TERM = TIMEOUT_W'(timeout_term(TIMEOUT_W));
  localparam logic [TIMEOUT_W-1:0] TO_PRE  = TO_TERM - 1'b1;

  state_t               state;
  logic [WIN_CNT_W-1:0] win_len_q;
  logic [WIN_CNT_W-1:0] win_cnt;
  logic [TIMEOUT_W-1:0] to_cnt;

  // Sequencer: window gating, clear pulses, result capture and timeout; stop overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      win_len_q        <= '0;
      win_cnt          <= '0;
      to_cnt           <= '0;
      rms_din_o        <= '0;
      rms_din_update_o <= 1'b0;
      rms_clr_o        <= 1'b0;
      result_o         <= '0;
      result_valid_o   <= 1'b0;
      busy_o           <= 1'b0;
      timeout_o        <= 1'b0;
    end else begin
      rms_din_update_o <= 1'b0;
      rms_clr_o        <= 1'b0;
      result_valid_o   <= 1'b0;
      if (stop_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_i && (win_len_i != '0)) begin
              win_len_q <= win_len_i;
              timeout_o <= 1'b0;
              rms_clr_o <= 1'b1;
              busy_o    <= 1'b1;
              state     <= CLEAR;
            end
          end
          CLEAR: begin
            win_cnt <= '0;
            state   <= ACQ;
          end
          ACQ: begin
            if (adc_valid_i) begin
              rms_din_o        <= adc_data_i;
              rms_din_update_o <= 1'b1;
              win_cnt          <= win_cnt + 1'b1;
              if ((win_cnt + 1'b1) == win_len_q) begin
                to_cnt <= '0;
                state  <= WAIT_RES;
              end
            end
          end
          WAIT_RES: begin
            if (rms_dout_update_i) begin
              result_o       <= rms_dout_i;
              result_valid_o <= 1'b1;
              if (cont_i) begin
                rms_clr_o <= 1'b1;
                state     <= CLEAR;
              end else begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end
            end else if (to_cnt == TO_PRE) begin
              to_cnt    <= TO_TERM;
              timeout_o <= 1'b1;
              busy_o    <= 1'b0;
              state     <= IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef STE_RMS_CTRL_PEAK_EN
  logic peak_clr;
  logic peak_fwd;
  logic peak_cap;

  assign peak_clr = (state == CLEAR) && !stop_i;
  assign peak_fwd = (state == ACQ) && adc_valid_i && !stop_i;
  assign peak_cap = (state == WAIT_RES) && rms_dout_update_i && !stop_i;

  ste_rms_ctrl_peak #(
    .DATA_W (DATA_W)
  ) u_peak (
    .clk          (clk),
    .rst          (rst),
    .clr          (peak_clr),
    .sample_valid (peak_fwd),
    .sample       (adc_data_i),
    .capture      (peak_cap),
    .peak_o       (peak_o)
  );
`endif

endmodule
